data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Shares the single-port DATA_Memory between two requesters: port 0 is the core MEM stage and port 1 is the loader/debug port.
- Arbitrates between the ports, latches the winner's request and drives the memory strobes with correct timing.
- Holds mem_write for a fixed multi-cycle window to satisfy the memory's two-phase write behaviour.
- Registers read data and returns a one-cycle done pulse to the winning requester.

Parameters:
- DATA_MEM_SIZE, 4000, number of words in the attached memory; used for the range check.
- WRITE_HOLD, 2, cycles that mem_write stays high per write; legal range 2..15.

Ports:
- clk  input  1  system clock; rising-edge.
- reset  input  1  synchronous, active-high reset.
- p0_req / p1_req  input  1  request; held high until the matching gnt is seen.
- p0_we / p1_we  input  1  1 = write, 0 = read.
- p0_addr / p1_addr  input  32  word address.
- p0_wdata / p1_wdata  input  32  write data.
- p0_gnt / p1_gnt  output  1  one-cycle pulse; request payload latched.
- p0_done / p1_done  output  1  one-cycle pulse; access finished.
- p0_rdata / p1_rdata  output  32  read result; valid while done is high, then held.
- err  output  1  one-cycle pulse alongside done when the address is out of range.
- mem_address  output  32  to DATA_Memory.
- data_in  output  32  to DATA_Memory.
- mem_read  output  1  to DATA_Memory.
- mem_write  output  1  to DATA_Memory.
- data_out  input  32  from DATA_Memory.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Registered outputs: every output is registered.
- Reset values: all outputs 0 (mem_address, data_in, rdata included); state = IDLE; hold counter = 0; round-robin pointer = port 0.
- Reset mid-operation: the pending access is abandoned. Strobes drop at the reset edge, and no done or err pulse is issued for the abandoned access.
- States: IDLE, READ, WRITE, RESP.
- IDLE: on an edge where any req is high, select the winner and latch its we/addr/wdata.
  - Pulse the winner's gnt for the next cycle.
  - If the address is >= DATA_MEM_SIZE, go to RESP with err pending; no strobes are asserted.
  - Otherwise, if we = 0: go to READ with mem_read = 1.
  - Otherwise: go to WRITE with mem_write = 1 and the hold counter loaded with WRITE_HOLD-1.
  - mem_address and data_in are driven from the latched values.
- READ: at the next edge, capture data_out into the winner's rdata, drop mem_read, go to RESP.
- WRITE: mem_address, data_in and mem_write stay stable. Decrement the counter each edge; when it is 0, drop mem_write and go to RESP. mem_write is therefore high for exactly WRITE_HOLD cycles.
- RESP: the winner's done is high for this cycle. err is high too if the range check failed; an out-of-range read returns rdata = 0. The next edge returns to IDLE.
- Latency, request sampled at edge E0:
  - gnt is high during E0..E1.
  - Read: done during E1..E2 → 2 cycles.
  - Write: done after WRITE_HOLD+1 cycles.
  - Out-of-range: done after 1 cycle.
- Throughput: at most one access per IDLE visit; back-to-back accesses from the same port are separated by one IDLE cycle.
- Simultaneous requests (default build): fixed priority, port 0 wins. Port 1 keeps waiting while p1_req is held.
- Requests are ignored outside IDLE. A requester may drop req after gnt; a req still high after done is treated as a new request.
- Non-winner outputs: the losing port's gnt, done and rdata are unchanged.
- Idle bus: strobes are never both high. In IDLE, mem_address and data_in keep their last values.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, the port that did not win the last grant wins. The pointer updates on every grant, and reset restores the pointer to port 0.
- Undefined: fixed priority with port 0 winning; no pointer register is built.

Test Plan:
- Read, addr 5 preloaded with 0x1234_5678, p0_req sampled at E0 -> p0_gnt during E0-E1, mem_read high one cycle, p0_done during E1-E2, p0_rdata = 0x1234_5678.
- Write, p1 addr 10 with data 0xDEAD_BEEF, WRITE_HOLD=2 -> mem_write high exactly 2 cycles with addr and data stable, p1_done 3 cycles after sampling; a later read of 10 returns 0xDEAD_BEEF.
- Both ports request continuously, default build -> p0 granted every IDLE visit and p1 never granted; with ARB_ROUND_ROBIN_EN -> grants alternate p0, p1, p0, p1.
- Address 4000, default DATA_MEM_SIZE -> no strobes asserted, done and err pulse together 1 cycle after sampling, rdata = 0.
- reset asserted during the 2nd WRITE cycle -> mem_write = 0 and all outputs 0 after that edge, no done pulse, next request serviced normally.
- Request arriving while a WRITE is in progress -> ignored until IDLE, then granted; no gnt pulse during the busy period.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port data memory between two requesters: port 0 is
//   the core MEM stage, port 1 is the loader/debug port. The winner's
//   request is latched, the memory strobes are sequenced (mem_write is held
//   for WRITE_HOLD cycles), read data is registered and a one-cycle done
//   pulse is returned to the winner.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   pN_req/we/addr/wdata       request from port N (req held until gnt)
//   pN_gnt                     one-cycle pulse, payload latched
//   pN_done                    one-cycle pulse, access finished
//   pN_rdata                   read result, valid with done, then held
//   err                        pulses with done on out-of-range address
//   mem_address/data_in        address / write data to the memory
//   mem_read/mem_write         memory strobes
//   data_out                   read data from the memory
//
// Build option
//   ARB_ROUND_ROBIN_EN         when defined, simultaneous requests alternate
//                              between ports; otherwise port 0 always wins.

module data_mem_arbiter #(
    parameter int DATA_MEM_SIZE = 4000,
    parameter int WRITE_HOLD    = 2     // legal range 2..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic [31:0] p1_rdata,
    output logic        err,
    output logic [31:0] mem_address,
    output logic [31:0] data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] data_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        win_q, win_d;          // port that owns the current access
    logic        p0_gnt_q, p0_gnt_d, p1_gnt_q, p1_gnt_d;
    logic        p0_done_q, p0_done_d, p1_done_q, p1_done_d;
    logic [31:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_address_q, mem_address_d, data_in_q, data_in_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic        prio_q, prio_d;        // port favoured on the next tie
`endif

    logic        sel;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        sel = p0_req ? (p1_req & prio_q) : 1'b1;
        prio_d = prio_q;
`else
        sel = ~p0_req;
`endif
        r_we    = sel ? p1_we    : p0_we;
        r_addr  = sel ? p1_addr  : p0_addr;
        r_wdata = sel ? p1_wdata : p0_wdata;

        state_d       = state_q;
        cnt_d         = cnt_q;
        win_d         = win_q;
        p0_gnt_d      = 1'b0;
        p1_gnt_d      = 1'b0;
        p0_done_d     = 1'b0;
        p1_done_d     = 1'b0;
        err_d         = 1'b0;
        p0_rdata_d    = p0_rdata_q;
        p1_rdata_d    = p1_rdata_q;
        mem_address_d = mem_address_q;
        data_in_d     = data_in_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    win_d         = sel;
                    p0_gnt_d      = ~sel;
                    p1_gnt_d      = sel;
                    mem_address_d = r_addr;
                    data_in_d     = r_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    prio_d        = ~sel;
`endif
                    if (r_addr >= 32'(DATA_MEM_SIZE)) begin
                        // Out of range: skip the memory, answer straight away.
                        state_d   = RESP;
                        err_d     = 1'b1;
                        p0_done_d = ~sel;
                        p1_done_d = sel;
                        if (!r_we) begin
                            if (sel) p1_rdata_d = '0;
                            else     p0_rdata_d = '0;
                        end
                    end else if (!r_we) begin
                        state_d    = READ;
                        mem_read_d = 1'b1;
                    end else begin
                        state_d     = WRITE;
                        mem_write_d = 1'b1;
                        cnt_d       = 4'(WRITE_HOLD - 1);
                    end
                end
            end
            READ: begin
                state_d   = RESP;
                p0_done_d = ~win_q;
                p1_done_d = win_q;
                if (win_q) p1_rdata_d = data_out;
                else       p0_rdata_d = data_out;
            end
            WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d   = RESP;
                    p0_done_d = ~win_q;
                    p1_done_d = win_q;
                end else begin
                    mem_write_d = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            win_q         <= 1'b0;
            p0_gnt_q      <= 1'b0;
            p1_gnt_q      <= 1'b0;
            p0_done_q     <= 1'b0;
            p1_done_q     <= 1'b0;
            p0_rdata_q    <= '0;
            p1_rdata_q    <= '0;
            err_q         <= 1'b0;
            mem_address_q <= '0;
            data_in_q     <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            win_q         <= win_d;
            p0_gnt_q      <= p0_gnt_d;
            p1_gnt_q      <= p1_gnt_d;
            p0_done_q     <= p0_done_d;
            p1_done_q     <= p1_done_d;
            p0_rdata_q    <= p0_rdata_d;
            p1_rdata_q    <= p1_rdata_d;
            err_q         <= err_d;
            mem_address_q <= mem_address_d;
            data_in_q     <= data_in_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
`ifdef ARB_ROUND_ROBIN_EN
            prio_q        <= prio_d;
`endif
        end
    end

    assign p0_gnt      = p0_gnt_q;
    assign p1_gnt      = p1_gnt_q;
    assign p0_done     = p0_done_q;
    assign p1_done     = p1_done_q;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;
    assign err         = err_q;
    assign mem_address = mem_address_q;
    assign data_in     = data_in_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;

endmodule
